// File: rtl/hack_pkg.sv
// ============================================================================
// Module   : hack_pkg
// Brief    : Shared definitions for the Hack program loader.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package hack_pkg;

  localparam int LOADER_LEN_W = 16;
  localparam int LOADER_SUM_W = 16;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    LEN_HI  = 4'd1,
    LEN_LO  = 4'd2,
    DATA_HI = 4'd3,
    DATA_LO = 4'd4,
    WRITE   = 4'd5,
    SUM_HI  = 4'd6,
    SUM_LO  = 4'd7,
    RUN     = 4'd8,
    ERROR   = 4'd9
  } loader_state_t;

endpackage

`default_nettype wire

// File: rtl/program_loader.sv
// ============================================================================
// Module   : program_loader
// Brief    : Fills the instruction ROM from a length-prefixed, checksummed byte
//            stream and releases the CPU only when the checksum matches.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module program_loader
  import hack_pkg::*;
#(
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              rom_we,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [15:0]       rom_wdata,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int CNT_W = ADDR_W + 1;
  localparam int CMP_W = (CNT_W > LOADER_LEN_W) ? CNT_W : LOADER_LEN_W;
  localparam logic [CMP_W-1:0] C_MAX_LEN = {{(CMP_W-1){1'b0}}, 1'b1} << ADDR_W;
  localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  loader_state_t            r_state;
  loader_state_t            w_nextState;
  logic [7:0]               r_hiByte;
  logic [LOADER_LEN_W-1:0]  r_len;
  logic [CNT_W-1:0]         r_count;
  logic [LOADER_SUM_W-1:0]  r_sum;
  logic [ADDR_W-1:0]        r_romAddr;
  logic [15:0]              r_romWdata;

  logic                     w_recv;
  logic                     w_idleLike;
  logic                     w_take;
  logic [15:0]              w_word;
  logic [CNT_W-1:0]         w_countInc;
  logic [CMP_W-1:0]         w_lenExt;
  logic [CMP_W-1:0]         w_newLenExt;
  logic [CMP_W-1:0]         w_countIncExt;

  always_comb begin
    w_recv = 1'b0;
    case (r_state)
      LEN_HI, LEN_LO, DATA_HI, DATA_LO, SUM_HI, SUM_LO: w_recv = 1'b1;
      default:                                          w_recv = 1'b0;
    endcase
  end

  assign w_idleLike = (r_state == IDLE) || (r_state == RUN) || (r_state == ERROR);
  assign w_take     = byte_valid & w_recv;
  assign w_word     = {r_hiByte, byte_data};
  assign w_countInc = r_count + C_CNT_ONE;

  // Bring length and counter to a common width so LEN = 2**ADDR_W compares exactly.
  always_comb begin
    w_lenExt                         = '0;
    w_lenExt[LOADER_LEN_W-1:0]       = r_len;
    w_newLenExt                      = '0;
    w_newLenExt[LOADER_LEN_W-1:0]    = w_word;
    w_countIncExt                    = '0;
    w_countIncExt[CNT_W-1:0]         = w_countInc;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE, RUN, ERROR: begin
        if (start) w_nextState = LEN_HI;
      end
      LEN_HI: begin
        if (w_take) w_nextState = LEN_LO;
      end
      LEN_LO: begin
        if (w_take) begin
          if (w_newLenExt > C_MAX_LEN) w_nextState = ERROR;
          else if (w_word == 16'h0000) w_nextState = SUM_HI;
          else                         w_nextState = DATA_HI;
        end
      end
      DATA_HI: begin
        if (w_take) w_nextState = DATA_LO;
      end
      DATA_LO: begin
        if (w_take) w_nextState = WRITE;
      end
      WRITE: begin
        if (w_countIncExt == w_lenExt) w_nextState = SUM_HI;
        else                           w_nextState = DATA_HI;
      end
      SUM_HI: begin
        if (w_take) w_nextState = SUM_LO;
      end
      SUM_LO: begin
        if (w_take) begin
          if (w_word == r_sum) w_nextState = RUN;
          else                 w_nextState = ERROR;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hiByte   <= '0;
      r_len      <= '0;
      r_count    <= '0;
      r_sum      <= '0;
      r_romAddr  <= '0;
      r_romWdata <= '0;
    end else begin
      if (w_idleLike && start) begin
        r_count <= '0;
        r_sum   <= '0;
      end
      if (w_take) begin
        case (r_state)
          LEN_HI, DATA_HI, SUM_HI: r_hiByte <= byte_data;
          LEN_LO:                  r_len    <= w_word;
          DATA_LO: begin
            // Address and data are latched together so both hold after the strobe.
            r_romWdata <= w_word;
            r_romAddr  <= r_count[ADDR_W-1:0];
          end
          default: ;
        endcase
      end
      if (r_state == WRITE) begin
        r_sum   <= r_sum + r_romWdata;
        r_count <= w_countInc;
      end
    end
  end

  assign byte_ready = w_recv;
  assign rom_we     = (r_state == WRITE);
  assign rom_addr   = r_romAddr;
  assign rom_wdata  = r_romWdata;
  assign cpu_reset  = (r_state != RUN);
  assign busy       = !w_idleLike;
  assign done       = (r_state == RUN);
  assign err        = (r_state == ERROR);

endmodule

`default_nettype wire

// File: tb/tb_program_loader.sv
// ============================================================================
// Module   : tb_program_loader
// Brief    : Self-checking bench for program_loader against a stream-level model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_program_loader;

  localparam int AW = 15;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          byte_valid = 1'b0;
  logic [7:0]    byte_data = 8'h00;
  logic          byte_ready;
  logic          rom_we;
  logic [AW-1:0] rom_addr;
  logic [15:0]   rom_wdata;
  logic          cpu_reset;
  logic          busy;
  logic          done;
  logic          err;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [AW+15:0] wrQ[$];

  program_loader #(.ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .start(start),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .rom_we(rom_we), .rom_addr(rom_addr), .rom_wdata(rom_wdata),
    .cpu_reset(cpu_reset), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (rom_we) wrQ.push_back({rom_addr, rom_wdata});

  // Serialise a program into the wire format: LEN, words, SUM, all big-endian.
  function automatic void build(input logic [15:0] w[$], input logic [15:0] sum,
                                output logic [7:0] s[$]);
    s = {};
    s.push_back(8'(w.size() >> 8));
    s.push_back(8'(w.size()));
    foreach (w[i]) begin
      s.push_back(w[i][15:8]);
      s.push_back(w[i][7:0]);
    end
    s.push_back(sum[15:8]);
    s.push_back(sum[7:0]);
  endfunction

  function automatic logic [15:0] model_sum(input logic [15:0] w[$]);
    int acc = 0;
    foreach (w[i]) acc = (acc + int'(w[i])) % 65536;
    return 16'(acc);
  endfunction

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b[$], input int gapPct, input bit poke,
                      output int firstCyc, output bit ok);
    bit acc;
    int guard;
    ok = 1'b1;
    firstCyc = -1;
    foreach (b[i]) begin
      acc = 1'b0;
      guard = 0;
      while (!acc && guard < 200) begin
        @(negedge clk);
        byte_valid = ($urandom_range(99) >= gapPct);
        byte_data  = byte_valid ? b[i] : 8'($urandom);
        start      = poke && ($urandom_range(4) == 0);
        acc        = byte_valid && byte_ready;
        if (acc && firstCyc < 0) firstCyc = cyc;
        @(posedge clk);
        guard++;
      end
      if (!acc) begin
        ok = 1'b0;
        return;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    total++;
    if ({cpu_reset, byte_ready, rom_we, busy, done, err} !== 6'b100000) begin
      bad++;
      $display("FAIL reset_flags: got %b want 100000", {cpu_reset, byte_ready, rom_we, busy, done, err});
    end
    total++;
    if (rom_addr !== '0 || rom_wdata !== '0) begin
      bad++;
      $display("FAIL reset_rom_bus: got addr=%h data=%h want 0/0", rom_addr, rom_wdata);
    end
    wrQ.delete();
    repeat (20) begin
      @(negedge clk);
      byte_valid = 1'($urandom);
      byte_data  = 8'($urandom);
    end
    byte_valid = 1'b0;
    total++;
    if (wrQ.size() != 0 || byte_ready !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle20: got writes=%0d ready=%b busy=%b want 0/0/0", wrQ.size(), byte_ready, busy);
    end
  endtask

  task automatic test_basic();
    logic [15:0] w[$] = '{16'h0010, 16'hEC10};
    logic [7:0]  s[$];
    int fc;
    bit ok;
    build(w, model_sum(w), s);
    wrQ.delete();
    pulse_start();
    total++;
    if (busy !== 1'b1 || byte_ready !== 1'b1 || cpu_reset !== 1'b1) begin
      bad++;
      $display("FAIL basic_start: got busy=%b ready=%b cpu_reset=%b want 1/1/1", busy, byte_ready, cpu_reset);
    end
    send(s, 0, 1'b0, fc, ok);
    @(negedge clk);
    byte_valid = 1'b0;
    total++;
    if (!ok) begin bad++; $display("FAIL basic_send: stream stalled, got timeout want accepted"); end
    total++;
    if (cyc - fc != 4 + 3 * w.size()) begin
      bad++;
      $display("FAIL basic_latency: got %0d cycles want %0d", cyc - fc, 4 + 3 * w.size());
    end
    total++;
    if ({done, cpu_reset, err, busy} !== 4'b1000) begin
      bad++;
      $display("FAIL basic_result: got done/cpu_reset/err/busy=%b want 1000", {done, cpu_reset, err, busy});
    end
    total++;
    if (wrQ.size() != 2) begin
      bad++;
      $display("FAIL basic_wr_count: got %0d want 2", wrQ.size());
    end
    for (int i = 0; i < 2 && i < wrQ.size(); i++) begin
      total++;
      if (wrQ[i] !== {AW'(i), w[i]}) begin
        bad++;
        $display("FAIL basic_wr%0d: got %h want %h", i, wrQ[i], {AW'(i), w[i]});
      end
    end
    total++;
    if (rom_addr !== AW'(1) || rom_wdata !== 16'hEC10) begin
      bad++;
      $display("FAIL basic_hold: got addr=%h data=%h want 1/ec10", rom_addr, rom_wdata);
    end
  endtask

  task automatic test_bad_sum();
    logic [15:0] w[$] = '{16'h0010, 16'hEC10};
    logic [7:0]  s[$];
    int fc;
    bit ok;
    build(w, 16'h0000, s);
    wrQ.delete();
    pulse_start();
    total++;
    if (cpu_reset !== 1'b1 || done !== 1'b0) begin
      bad++;
      $display("FAIL restart_from_run: got cpu_reset=%b done=%b want 1/0", cpu_reset, done);
    end
    send(s, 0, 1'b0, fc, ok);
    @(negedge clk);
    byte_valid = 1'b0;
    total++;
    if (!ok || {err, cpu_reset, done} !== 3'b110 || wrQ.size() != 2) begin
      bad++;
      $display("FAIL bad_sum: got ok=%b err/cpu_reset/done=%b writes=%0d want 1/110/2", ok, {err, cpu_reset, done}, wrQ.size());
    end
    build(w, model_sum(w), s);
    pulse_start();
    total++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL restart_from_err: got err=%b busy=%b want 0/1", err, busy);
    end
    send(s, 0, 1'b0, fc, ok);
    @(negedge clk);
    byte_valid = 1'b0;
    total++;
    if (!ok || {done, cpu_reset, err} !== 3'b100) begin
      bad++;
      $display("FAIL recover_after_err: got ok=%b done/cpu_reset/err=%b want 1/100", ok, {done, cpu_reset, err});
    end
  endtask

  task automatic test_zero_len();
    logic [15:0] w[$] = {};
    logic [7:0]  s[$];
    int fc;
    bit ok;
    build(w, model_sum(w), s);
    wrQ.delete();
    pulse_start();
    send(s, 0, 1'b0, fc, ok);
    @(negedge clk);
    byte_valid = 1'b0;
    total++;
    if (!ok || wrQ.size() != 0 || done !== 1'b1 || cyc - fc != 4) begin
      bad++;
      $display("FAIL zero_len: got ok=%b writes=%0d done=%b cycles=%0d want 1/0/1/4", ok, wrQ.size(), done, cyc - fc);
    end
  endtask

  task automatic test_len_limits();
    logic [7:0] s[$];
    int fc;
    bit ok;
    bit sawReady;
    s = '{8'h80, 8'h01};
    wrQ.delete();
    pulse_start();
    send(s, 0, 1'b0, fc, ok);
    @(negedge clk);
    total++;
    if (!ok || {err, byte_ready, cpu_reset, busy} !== 4'b1010) begin
      bad++;
      $display("FAIL len_too_big: got ok=%b err/ready/cpu_reset/busy=%b want 1/1010", ok, {err, byte_ready, cpu_reset, busy});
    end
    sawReady = 1'b0;
    repeat (10) begin
      byte_valid = 1'b1;
      byte_data  = 8'($urandom);
      @(negedge clk);
      sawReady |= byte_ready;
    end
    byte_valid = 1'b0;
    total++;
    if (sawReady || wrQ.size() != 0 || err !== 1'b1) begin
      bad++;
      $display("FAIL len_too_big_hold: got ready_seen=%b writes=%0d err=%b want 0/0/1", sawReady, wrQ.size(), err);
    end
    // LEN equal to the full ROM capacity must be accepted; abort it with reset.
    s = '{8'h80, 8'h00};
    pulse_start();
    send(s, 0, 1'b0, fc, ok);
    @(negedge clk);
    byte_valid = 1'b0;
    total++;
    if (!ok || {err, busy, byte_ready} !== 3'b011) begin
      bad++;
      $display("FAIL len_max_legal: got ok=%b err/busy/ready=%b want 1/011", ok, {err, busy, byte_ready});
    end
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_random();
    logic [15:0] w[$];
    logic [7:0]  s[$];
    logic [15:0] sum;
    bit badSum;
    bit ok;
    int fc;
    for (int it = 0; it < 8; it++) begin
      w = {};
      if (it == 0) begin
        w = '{16'h0010, 16'hEC10};
        badSum = 1'b0;
      end else begin
        repeat ($urandom_range(12, 1)) w.push_back(16'($urandom));
        badSum = ($urandom_range(2) == 0);
      end
      sum = model_sum(w);
      if (badSum) sum = sum ^ 16'($urandom_range(65535, 1));
      build(w, sum, s);
      wrQ.delete();
      pulse_start();
      send(s, 40, 1'b1, fc, ok);
      @(negedge clk);
      byte_valid = 1'b0;
      start = 1'b0;
      total++;
      if (!ok || {done, err, cpu_reset} !== (badSum ? 3'b011 : 3'b100)) begin
        bad++;
        $display("FAIL rand%0d_result: got ok=%b done/err/cpu_reset=%b want 1/%b", it, ok, {done, err, cpu_reset}, badSum ? 3'b011 : 3'b100);
      end
      total++;
      if (wrQ.size() != w.size()) begin
        bad++;
        $display("FAIL rand%0d_wr_count: got %0d want %0d", it, wrQ.size(), w.size());
      end
      for (int i = 0; i < w.size() && i < wrQ.size(); i++) begin
        total++;
        if (wrQ[i] !== {AW'(i), w[i]}) begin
          bad++;
          $display("FAIL rand%0d_wr%0d: got %h want %h", it, i, wrQ[i], {AW'(i), w[i]});
        end
      end
    end
  endtask

  task automatic test_reset_midload();
    logic [15:0] w[$] = '{16'h0010, 16'hEC10};
    logic [7:0]  s[$];
    logic [7:0]  part[$];
    int fc;
    bit ok;
    build(w, model_sum(w), s);
    part = '{8'h00, 8'h02, 8'h00, 8'h10};
    pulse_start();
    send(part, 0, 1'b0, fc, ok);
    @(negedge clk);
    byte_valid = 1'b0;
    total++;
    if (!ok || rom_we !== 1'b1) begin
      bad++;
      $display("FAIL midload_first_write: got ok=%b rom_we=%b want 1/1", ok, rom_we);
    end
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    total++;
    if ({cpu_reset, byte_ready, rom_we, busy, done, err} !== 6'b100000 || rom_addr !== '0 || rom_wdata !== '0) begin
      bad++;
      $display("FAIL midload_reset: got flags=%b addr=%h data=%h want 100000/0/0",
               {cpu_reset, byte_ready, rom_we, busy, done, err}, rom_addr, rom_wdata);
    end
    @(negedge clk);
    reset = 1'b1;
    wrQ.delete();
    pulse_start();
    send(s, 0, 1'b0, fc, ok);
    @(negedge clk);
    byte_valid = 1'b0;
    total++;
    if (!ok || done !== 1'b1 || wrQ.size() != 2 || (wrQ.size() == 2 && wrQ[1] !== {AW'(1), 16'hEC10})) begin
      bad++;
      $display("FAIL midload_reload: got ok=%b done=%b writes=%0d want 1/1/2", ok, done, wrQ.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bad_sum();
    test_zero_len();
    test_len_limits();
    test_random();
    test_reset_midload();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/program_loader.md
# program_loader

Boot-time sequencer that fills the Hack instruction ROM from a byte stream and then starts the CPU. It holds the CPU in reset, accepts a length-prefixed, checksummed program over a valid/ready byte handshake, and writes one 16-bit instruction per ROM write cycle. It releases the CPU only after the checksum matches. It sits between the host link (UART receiver or test bench) and the ROM write port, and it drives the CPU `reset` input.

## Interface
- `ADDR_W`, default 15: ROM address width; capacity is 2**ADDR_W words.
- `clk`, in, 1: single clock; all state changes on the rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: one-cycle request to begin a load.
- `byte_valid`, in, 1: `byte_data` is valid.
- `byte_data`, in, 8: incoming stream byte.
- `byte_ready`, out, 1: loader accepts a byte this cycle.
- `rom_we`, out, 1: ROM write strobe.
- `rom_addr`, out, ADDR_W: ROM write address.
- `rom_wdata`, out, 16: instruction word to write.
- `cpu_reset`, out, 1: active-high reset to CPU/PC.
- `busy`, out, 1: load in progress.
- `done`, out, 1: load succeeded; CPU running.
- `err`, out, 1: load failed (length or checksum).

## Operation
- Stream format, all fields big-endian (high byte first):
  - `LEN` (16 bits).
  - `LEN` instruction words.
  - `SUM` (16 bits) = modulo-2^16 sum of all words.
- States: `IDLE`, `LEN_HI`, `LEN_LO`, `DATA_HI`, `DATA_LO`, `WRITE`, `SUM_HI`, `SUM_LO`, `RUN`, `ERROR`.
- `IDLE`:
  - `start` clears the word counter, the running sum, `done` and `err`, then goes to `LEN_HI`.
- Receive states (`LEN_*`, `DATA_*`, `SUM_*`):
  - `byte_ready`=1.
  - A byte is taken only when `byte_valid & byte_ready`, then the FSM advances. Otherwise it holds.
- After `LEN_LO`:
  - `LEN` > 2**ADDR_W → `ERROR`.
  - `LEN` = 0 → `SUM_HI`.
  - Otherwise → `DATA_HI`.
- After `DATA_LO`: → `WRITE`.
- `WRITE` (one cycle):
  - `rom_we`=1, `rom_addr`=counter, `rom_wdata`=assembled word.
  - Sum += word; counter += 1.
  - → `SUM_HI` if the counter reaches `LEN`, else → `DATA_HI`.
  - `byte_ready`=0 in this state.
- After `SUM_LO`:
  - Received `SUM` equal to the running sum → `RUN`.
  - Otherwise → `ERROR`.
- `RUN`: `cpu_reset`=0, `done`=1.
- `ERROR`: `err`=1, `cpu_reset`=1.
- `busy`=1 in every state except `IDLE`, `RUN` and `ERROR`.
- `cpu_reset`=1 in every state except `RUN`.
- Boundary rules:
  - `start` while busy: ignored.
  - `start` in `RUN` or `ERROR`: same as from `IDLE`; `cpu_reset` is reasserted at that edge.
  - Counter width is ADDR_W+1, so that `LEN` = 2**ADDR_W is legal and no wrap occurs. `rom_addr` = counter[ADDR_W-1:0].
  - `byte_valid` outside receive states: ignored, with no byte consumed.
  - Reset asserted mid-load: immediate return to the reset state. Partial ROM contents are left as written.

## Timing
- Reset values:
  - State `IDLE`.
  - `cpu_reset`=1.
  - `byte_ready`=0, `rom_we`=0, `busy`=0, `done`=0, `err`=0.
  - `rom_addr`=0, `rom_wdata`=0, counter=0, sum=0.
- All outputs are registered or decoded from the state register. There is no combinational path from inputs to outputs.
- `start` at edge N → `busy`=1 and `byte_ready`=1 from cycle N+1.
- With `byte_valid` held high, each word costs 3 cycles (HI, LO, WRITE).
- Total load length = 2+3·LEN+2 cycles from the first accepted byte to `RUN`/`ERROR`.
- `cpu_reset` falls in the cycle after the `SUM_LO` byte is accepted. This is the same cycle `done` rises.
- `rom_wdata` and `rom_addr` hold their values after `rom_we` drops.

## Structure
- `hack_pkg` holds the shared definitions:
  - `loader_state_t` enum.
  - Constants `LOADER_LEN_W`=16 and `LOADER_SUM_W`=16.
- Single module with no sub-module.
- The byte-pair assembly is an 8-bit high-byte holding register inside the FSM.

## Test plan
- Reset with inputs idle → `cpu_reset`=1, all other outputs 0, `byte_ready`=0. No `rom_we` for 20 cycles.
- `start`, then bytes 00 02 00 10 EC 10 EC 20:
  - ROM writes addr0=0x0010 and addr1=0xEC10, one `rom_we` pulse each.
  - `done`=1 and `cpu_reset`=0 on the cycle after the last byte.
- Same stream with checksum 00 00 → `err`=1, `cpu_reset` stays 1, `done`=0. A new `start` with a good stream then succeeds.
- Bytes 00 00 00 00 → no `rom_we`, `done`=1.
  - Also: with `ADDR_W`=15, bytes 80 01 → `ERROR` right after `LEN_LO`, no writes, remaining bytes not accepted.
- Randomly gapped `byte_valid` during the load in the second scenario → identical ROM contents and result. `start` pulses during the load are ignored.
- Reset pulled low after the first data word is written → all outputs return to reset values at once. A subsequent full load succeeds.
